// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 types and constants
//
// Holds the message-arbiter FSM state encoding, the digest width and the
// SM3 initial chaining value. Imported by the arbiter RTL and its bench.

package sm3_pkg;

  // Message arbiter states: waiting for a requester, streaming the owner's
  // words into the pipeline, waiting for the digest of that message.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2
  } sm3_arb_state_e;

  localparam int SM3_DIGEST_W = 256;

  // SM3 initial value (V0), most significant word first.
  localparam logic [SM3_DIGEST_W-1:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

endpackage

// File: rtl/sm3_rr_pick.sv
// rtl/sm3_rr_pick.sv - combinational round-robin priority picker
//
// Picks the first set request bit at or after ptr, scanning upward and
// wrapping from N-1 back to 0.
//
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index with highest priority this cycle (must be < N)
//   gnt  out N   one-hot grant (all zero when no request)
//   idx  out IW  index of the granted request (0 when no request)
//   any  out 1   at least one request is set

module sm3_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW:0]   j;
    logic [IW-1:0] jn;
    j   = '0;
    jn  = '0;
    idx = '0;
    any = |req;
    // Walk offsets from farthest to nearest so the nearest set bit
    // (smallest offset from ptr) is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) begin
        j = j - (IW+1)'(N);
      end
      jn = j[IW-1:0];
      if (req[jn]) begin
        idx = jn;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/sm3_msg_arb.sv
// rtl/sm3_msg_arb.sv - per-message round-robin arbiter for a shared SM3 pipeline
//
// A requester wins the pipeline from its first word until the digest of its
// message returns (or the watchdog aborts it); only one message is ever in
// flight because the compression core keeps chaining state for one message.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_vld_i        per-requester word valid
//   req_data_i       per-requester word, requester k at [k*DW +: DW]
//   req_lst_i        per-requester last-word flag
//   req_rdy_o        per-requester ready (only the owner, only while streaming)
//   sm3_vld_o        word valid to the pipeline
//   sm3_data_o       word to the pipeline (zero when not valid)
//   sm3_lst_o        last-word flag to the pipeline
//   sm3_rdy_i        pipeline ready
//   sm3_res_vld_i    digest valid pulse from the compression core
//   sm3_res_i        digest from the compression core
//   res_vld_o        one-hot digest pulse to the owner (cycle after the digest)
//   res_o            registered digest, shared by all requesters
//   busy_o           a message is granted or in flight
//   owner_o          current or most recent owner
//   err_timeout_o    watchdog abort pulse, in the last cycle of WAIT
//   err_spurious_o   pulse (next cycle) for a digest arriving outside WAIT

module sm3_msg_arb
  import sm3_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_vld_i,
  input  logic [NUM_REQ*DW-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]      req_lst_i,
  output logic [NUM_REQ-1:0]      req_rdy_o,
  output logic                    sm3_vld_o,
  output logic [DW-1:0]           sm3_data_o,
  output logic                    sm3_lst_o,
  input  logic                    sm3_rdy_i,
  input  logic                    sm3_res_vld_i,
  input  logic [SM3_DIGEST_W-1:0] sm3_res_i,
  output logic [NUM_REQ-1:0]      res_vld_o,
  output logic [SM3_DIGEST_W-1:0] res_o,
  output logic                    busy_o,
  output logic [IDW-1:0]          owner_o,
  output logic                    err_timeout_o,
  output logic                    err_spurious_o
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_XFER = ST_XFER;
  localparam logic [1:0] S_WAIT = ST_WAIT;

  // The watchdog only ever needs to count up to TIMEOUT_CYC-1.
  localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  logic [1:0]         state;
  logic [IDW-1:0]     owner;
  logic [NUM_REQ-1:0] owner_oh;
  logic [IDW-1:0]     ptr;
  logic [WDW-1:0]     wdog;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  logic               own_vld;
  logic               own_lst;
  logic [DW-1:0]      own_data;
  logic               in_xfer;
  logic               in_wait;
  logic               beat_last;
  logic [IDW-1:0]     next_ptr;

  sm3_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .req (req_vld_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the owner's lane. owner_oh is kept alongside owner so the lane
  // mux, ready fan-out and result pulse need no decoder.
  always_comb begin
    own_vld  = 1'b0;
    own_lst  = 1'b0;
    own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_oh[k]) begin
        own_vld  = req_vld_i[k];
        own_lst  = req_lst_i[k];
        own_data = req_data_i[k*DW +: DW];
      end
    end
  end

  assign in_xfer = (state == S_XFER);
  assign in_wait = (state == S_WAIT);

  assign sm3_vld_o  = in_xfer & own_vld;
  assign sm3_data_o = sm3_vld_o ? own_data : '0;
  assign sm3_lst_o  = in_xfer & own_lst;
  assign req_rdy_o  = in_xfer ? (owner_oh & {NUM_REQ{sm3_rdy_i}}) : '0;

  assign beat_last = sm3_vld_o & sm3_rdy_i & sm3_lst_o;

  assign busy_o  = (state != S_IDLE);
  assign owner_o = owner;

  // A digest arriving in the very cycle the watchdog expires still wins.
  assign err_timeout_o = in_wait & (wdog == WD_LAST) & ~sm3_res_vld_i;

  assign next_ptr = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      owner          <= '0;
      owner_oh       <= '0;
      ptr            <= '0;
      wdog           <= '0;
      res_o          <= '0;
      res_vld_o      <= '0;
      err_spurious_o <= 1'b0;
    end else begin
      res_vld_o      <= '0;
      err_spurious_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sm3_res_vld_i) begin
            err_spurious_o <= 1'b1;
          end
          if (pick_any) begin
            owner    <= pick_idx;
            owner_oh <= pick_gnt;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (sm3_res_vld_i) begin
            err_spurious_o <= 1'b1;
          end
          if (beat_last) begin
            wdog  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sm3_res_vld_i) begin
            res_o     <= sm3_res_i;
            res_vld_o <= owner_oh;
            ptr       <= next_ptr;
            state     <= S_IDLE;
          end else if (wdog == WD_LAST) begin
            // Abort: no result pulse, the owner loses its turn.
            ptr   <= next_ptr;
            state <= S_IDLE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_msg_arb.sv
// tb/tb_sm3_msg_arb.sv - self-checking bench for sm3_msg_arb

module tb_sm3_msg_arb;
  import sm3_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam logic [255:0] ABC_DIG =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

  localparam int M_IDLE = 0;
  localparam int M_XFER = 1;
  localparam int M_WAIT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld_i, req_lst_i, req_rdy_o, res_vld_o;
  logic [N*DW-1:0] req_data_i;
  logic            sm3_vld_o, sm3_lst_o, sm3_rdy_i, sm3_res_vld_i;
  logic [DW-1:0]   sm3_data_o;
  logic [255:0]    sm3_res_i, res_o;
  logic            busy_o, err_timeout_o, err_spurious_o;
  logic [1:0]      owner_o;

  sm3_msg_arb #(
    .NUM_REQ     (N),
    .DW          (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_vld_i      (req_vld_i),
    .req_data_i     (req_data_i),
    .req_lst_i      (req_lst_i),
    .req_rdy_o      (req_rdy_o),
    .sm3_vld_o      (sm3_vld_o),
    .sm3_data_o     (sm3_data_o),
    .sm3_lst_o      (sm3_lst_o),
    .sm3_rdy_i      (sm3_rdy_i),
    .sm3_res_vld_i  (sm3_res_vld_i),
    .sm3_res_i      (sm3_res_i),
    .res_vld_o      (res_vld_o),
    .res_o          (res_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .err_timeout_o  (err_timeout_o),
    .err_spurious_o (err_spurious_o)
  );

  initial forever #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // requester word queues {lst, data}, digest queue, observation logs
  logic [32:0]  rq [N][$];
  logic [255:0] dig_q [$];
  logic [32:0]  beats [$];
  logic [N-1:0] resv_log [$];
  logic [255:0] res_log [$];
  int cyc = 0, cyc_lst = 0, cyc_tmo = 0, n_tmo = 0, n_spur = 0;
  logic [N-1:0] acc_n = '0;
  logic lst_acc = 1'b0;
  bit rdy_rand = 0, withhold = 0, inject = 0;
  int dcnt = 0;

  // behavioural model
  int m_mode = M_IDLE, m_owner = 0, m_ptr = 0, m_wcnt = 0;
  logic [N-1:0] m_resv = '0;
  logic [255:0] m_res = '0;
  bit m_spur = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_cycle();
    logic [N-1:0] e_rdy, e_resv;
    logic e_vld, e_lst, e_busy, e_tmo, e_spur;
    logic [DW-1:0] e_data;
    logic [255:0] e_res;
    logic [1:0] e_own;
    cyc++;
    if (!rst_n) begin
      e_rdy = '0; e_resv = '0; e_vld = 0; e_lst = 0; e_busy = 0; e_tmo = 0;
      e_spur = 0; e_data = '0; e_res = '0; e_own = '0;
      m_mode = M_IDLE; m_owner = 0; m_ptr = 0; m_wcnt = 0;
      m_resv = '0; m_res = '0; m_spur = 0;
    end else begin
      e_vld  = (m_mode == M_XFER) && req_vld_i[m_owner];
      e_data = e_vld ? req_data_i[m_owner*DW +: DW] : '0;
      e_lst  = (m_mode == M_XFER) && req_lst_i[m_owner];
      e_rdy  = (m_mode == M_XFER && sm3_rdy_i) ? N'(1 << m_owner) : '0;
      e_busy = (m_mode != M_IDLE);
      e_own  = 2'(m_owner);
      e_resv = m_resv;
      e_res  = m_res;
      e_spur = m_spur;
      e_tmo  = (m_mode == M_WAIT) && (m_wcnt == TMO - 1) && !sm3_res_vld_i;
    end
    chk("req_rdy_o", req_rdy_o, e_rdy);
    chk("sm3_vld_o", sm3_vld_o, e_vld);
    chk("sm3_data_o", sm3_data_o, e_data);
    chk("sm3_lst_o", sm3_lst_o, e_lst);
    chk("busy_o", busy_o, e_busy);
    chk("owner_o", owner_o, e_own);
    chk("res_vld_o", res_vld_o, e_resv);
    chk("res_o", res_o, e_res);
    chk("err_timeout_o", err_timeout_o, e_tmo);
    chk("err_spurious_o", err_spurious_o, e_spur);

    acc_n   = rst_n ? (req_vld_i & req_rdy_o) : '0;
    lst_acc = rst_n & sm3_vld_o & sm3_rdy_i & sm3_lst_o;
    if (lst_acc) cyc_lst = cyc;
    if (rst_n && sm3_vld_o && sm3_rdy_i) beats.push_back({sm3_lst_o, sm3_data_o});
    if (res_vld_o != '0) begin
      resv_log.push_back(res_vld_o);
      res_log.push_back(res_o);
    end
    if (err_timeout_o) begin n_tmo++; cyc_tmo = cyc; end
    if (err_spurious_o) n_spur++;

    if (rst_n) begin
      m_resv = '0;
      m_spur = 0;
      if (m_mode == M_IDLE) begin
        if (sm3_res_vld_i) m_spur = 1;
        if (req_vld_i != '0) begin
          for (int i = 0; i < N; i++) begin
            if (req_vld_i[(m_ptr + i) % N]) begin
              m_owner = (m_ptr + i) % N;
              break;
            end
          end
          m_mode = M_XFER;
        end
      end else if (m_mode == M_XFER) begin
        if (sm3_res_vld_i) m_spur = 1;
        if (req_vld_i[m_owner] && sm3_rdy_i && req_lst_i[m_owner]) begin
          m_mode = M_WAIT;
          m_wcnt = 0;
        end
      end else begin
        if (sm3_res_vld_i) begin
          m_res  = sm3_res_i;
          m_resv = N'(1 << m_owner);
          m_ptr  = (m_owner + 1) % N;
          m_mode = M_IDLE;
        end else if (m_wcnt == TMO - 1) begin
          m_ptr  = (m_owner + 1) % N;
          m_mode = M_IDLE;
        end else begin
          m_wcnt++;
        end
      end
    end
  endtask

  task automatic drive();
    logic [32:0] w;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) rq[k].delete();
      dcnt = 0;
      inject = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (acc_n[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    end
    for (int k = 0; k < N; k++) begin
      if (rst_n && rq[k].size() > 0) begin
        w = rq[k][0];
        req_vld_i[k] = 1'b1;
        req_lst_i[k] = w[32];
        req_data_i[k*DW +: DW] = w[31:0];
      end else begin
        req_vld_i[k] = 1'b0;
        req_lst_i[k] = 1'b0;
        req_data_i[k*DW +: DW] = '0;
      end
    end
    sm3_res_vld_i = 1'b0;
    sm3_res_i = '0;
    if (rst_n) begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          sm3_res_vld_i = 1'b1;
          sm3_res_i = (dig_q.size() > 0) ? dig_q.pop_front() : SM3_IV;
        end
      end
      if (lst_acc && !withhold) dcnt = 3;
      if (inject) begin
        sm3_res_vld_i = 1'b1;
        sm3_res_i = SM3_IV;
        inject = 0;
      end
    end
    sm3_rdy_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_res(input int n, input string name);
    int t = 0;
    while (resv_log.size() < n && t < 600) begin
      tick();
      t++;
    end
    chk(name, resv_log.size() >= n, 1'b1);
  endtask

  task automatic push_msg(input int k, input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) rq[k].push_back({i == len - 1, base + 32'(i)});
  endtask

  task automatic push_abc(input int k);
    rq[k].push_back({1'b0, 32'h61626380});
    for (int i = 1; i < 15; i++) rq[k].push_back(33'd0);
    rq[k].push_back({1'b1, 32'h00000018});
  endtask

  initial begin
    int base, b0, viol, errs, nt0, ns0, r0, t;
    logic [32:0] bw;
    logic [N-1:0] rv;
    rst_n = 1'b0;
    req_vld_i = '0; req_lst_i = '0; req_data_i = '0;
    sm3_rdy_i = 1'b1; sm3_res_vld_i = 1'b0; sm3_res_i = '0;

    // reset state
    ticks(3);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_owner", owner_o, 2'd0);
    chk("reset_res", res_o, '0);
    rst_n = 1'b1;
    ticks(2);

    // requesters 1 and 3 together from pointer 0; 1 re-requests at once
    dig_q.push_back(SM3_IV ^ 256'd1);
    dig_q.push_back(SM3_IV ^ 256'd3);
    dig_q.push_back(SM3_IV ^ 256'd5);
    push_msg(1, 2, 32'h11110000);
    push_msg(3, 3, 32'h33330000);
    push_msg(1, 1, 32'h11118000);
    wait_res(3, "rr_done");
    rv = resv_log[0]; chk("rr_first_1", rv, 4'b0010);
    rv = resv_log[1]; chk("rr_second_3", rv, 4'b1000);
    rv = resv_log[2]; chk("rr_third_1", rv, 4'b0010);
    chk("rr_digest_3", res_log[1], SM3_IV ^ 256'd3);
    chk("model_ptr_after_rr", 256'(m_ptr), 256'd2);

    // "abc" from requester 0, requester 2 arrives mid-transfer
    base = resv_log.size();
    push_abc(0);
    dig_q.push_back(ABC_DIG);
    ticks(5);
    push_msg(2, 1, 32'hcafe0002);
    dig_q.push_back(SM3_IV ^ 256'd2);
    viol = 0;
    t = 0;
    while (resv_log.size() < base + 1 && t < 600) begin
      if (req_rdy_o[2]) viol++;
      tick();
      t++;
    end
    rv = resv_log[base]; chk("abc_res_vld", rv, 4'b0001);
    chk("abc_digest", res_log[base], ABC_DIG);
    chk("rq2_locked_out", viol, 0);
    chk("rq2_grant_busy", busy_o, 1'b1);
    chk("rq2_grant_owner", owner_o, 2'd2);
    wait_res(base + 2, "rq2_done");
    rv = resv_log[base + 1]; chk("rq2_res_vld", rv, 4'b0100);

    // 32-word two-block message with random pipeline back-pressure
    b0 = beats.size();
    base = resv_log.size();
    rdy_rand = 1;
    dig_q.push_back(SM3_IV ^ 256'd32);
    push_msg(1, 32, 32'h10000000);
    wait_res(base + 1, "blk_done");
    rdy_rand = 0;
    chk("blk_beats", beats.size() - b0, 32);
    errs = 0;
    for (int i = 0; i < 32 && b0 + i < beats.size(); i++) begin
      bw = beats[b0 + i];
      if (bw[31:0] != 32'h10000000 + 32'(i) || bw[32] != (i == 31)) errs++;
    end
    chk("blk_order_lst", errs, 0);

    // withheld digest -> watchdog, then a late digest is spurious
    withhold = 1;
    nt0 = n_tmo;
    r0 = resv_log.size();
    push_msg(3, 2, 32'h33338000);
    t = 0;
    while (n_tmo == nt0 && t < 200) begin
      tick();
      t++;
    end
    chk("tmo_seen", n_tmo - nt0, 1);
    chk("tmo_latency", cyc_tmo - cyc_lst, 16);
    ticks(3);
    chk("tmo_no_res", resv_log.size(), r0);
    withhold = 0;
    ns0 = n_spur;
    inject = 1;
    ticks(3);
    chk("spur_pulse", n_spur - ns0, 1);
    chk("spur_no_res", resv_log.size(), r0);
    chk("spur_idle", busy_o, 1'b0);

    // reset in the middle of a transfer, then a fresh arbitration
    push_msg(2, 10, 32'h22220000);
    ticks(6);
    chk("pre_rst_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_rdy", req_rdy_o, 4'b0000);
    chk("rst_mid_vld", sm3_vld_o, 1'b0);
    chk("rst_mid_owner", owner_o, 2'd0);
    tick();
    rst_n = 1'b1;
    ticks(2);
    base = resv_log.size();
    dig_q.delete();
    dig_q.push_back(SM3_IV ^ 256'd7);
    dig_q.push_back(SM3_IV ^ 256'd9);
    push_msg(3, 2, 32'h3333c000);
    push_msg(1, 3, 32'h1111c000);
    wait_res(base + 2, "post_rst_done");
    rv = resv_log[base]; chk("post_rst_first_1", rv, 4'b0010);
    rv = resv_log[base + 1]; chk("post_rst_second_3", rv, 4'b1000);
    chk("post_rst_digest", res_log[base + 1], SM3_IV ^ 256'd9);
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
